prescaler_sched: RTL
====================

PRESCALER_SCHED -- requirements
Module: prescaler_sched

Interface
REQ-001 SHALL have parameter N, default 22, prescaler counter width in bits (base tick period 2^N clk_in cycles).
REQ-002 SHALL have parameter W, default 8, channel period width in base ticks.
REQ-003 SHALL have port clk_in  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  synchronous active-low reset.
REQ-005 SHALL have port cfg_valid  input  1  configuration request.
REQ-006 SHALL have port cfg_ready  output  1  controller can accept configuration.
REQ-007 SHALL have port cfg_ch  input  2  target channel 0..3.
REQ-008 SHALL have port cfg_period  input  W  channel period in base ticks; 0 = stop channel.
REQ-009 SHALL have port cfg_mode  input  1  0 = one-shot, 1 = periodic.
REQ-010 SHALL have port tick_base  output  1  one-cycle pulse per prescaler wrap.
REQ-011 SHALL have port tick  output  4  per-channel one-cycle event pulses.
REQ-012 SHALL have port busy  output  4  per-channel active flag.

Function
REQ-013 SHALL contain one free-running N-bit counter, +1 every clk_in cycle, wrapping 2^N-1 -> 0.
REQ-014 tick_base SHALL be registered and high exactly one cycle when the counter wraps, i.e. at cycles k*2^N after reset release, k >= 1.
REQ-015 Config FSM SHALL have states READY (cfg_ready=1) and APPLY (cfg_ready=0).
REQ-016 READY -> APPLY SHALL occur when cfg_valid && cfg_ready; cfg_ch/cfg_period/cfg_mode SHALL be captured on that edge.
REQ-017 APPLY -> READY SHALL occur unconditionally after one cycle; cfg_valid in APPLY SHALL be ignored.
REQ-018 At the end of APPLY the target channel SHALL load remaining = period, mode = cfg_mode, busy = (period != 0).
REQ-019 A load on a busy channel SHALL override it; counting restarts from the new period.
REQ-020 A base tick coinciding with the APPLY cycle SHALL NOT decrement the channel being loaded; other channels SHALL be unaffected.
REQ-021 On each base tick, each busy channel with remaining > 1 SHALL decrement remaining.
REQ-022 On a base tick with remaining == 1, tick[ch] SHALL pulse in the same cycle as tick_base; periodic reloads remaining = period, one-shot clears busy in that cycle.
REQ-023 Result: first tick[ch] on the period-th tick_base after load; periodic repeats every period tick_bases.
REQ-024 Non-busy channels SHALL never assert tick; period 0 SHALL clear busy without a tick.
REQ-025 Multiple channels expiring on the same base tick SHALL all pulse simultaneously (no arbitration loss).

Reset
REQ-026 rstn low at a rising edge SHALL clear: counter = 0, tick_base = 0, tick = 0, busy = 0, all remaining/period/mode = 0, FSM = READY.
REQ-027 cfg_ready SHALL be 1 in the first cycle after reset release; reset SHALL abort an in-progress APPLY without loading.

Configuration
REQ-028 Macro PRESCALER_SCHED_PAUSE_EN defined SHALL add port pause  input  1; while pause = 1 the counter, tick_base, and all channel counters SHALL freeze (tick = 0, tick_base = 0), config handshake SHALL continue to operate.
REQ-029 Without PRESCALER_SCHED_PAUSE_EN the pause port SHALL NOT exist and the counter SHALL always run.

Verification (N=4, W=8)
REQ-030 Reset, no config -> cfg_ready=1, busy=0, tick=0; tick_base high at cycles 16, 32, 48 only.
REQ-031 Load ch0 period=3 mode=1 -> tick[0] coincides with 3rd, 6th, 9th tick_base after load; busy[0]=1 throughout.
REQ-032 Load ch1 period=2 mode=0 -> single tick[1] on 2nd tick_base; busy[1] falls same cycle; no further tick[1].
REQ-033 ch0 running, load ch0 period=0 -> busy[0]=0 after APPLY, no further tick[0]; cfg_ready low exactly one cycle per accept.
REQ-034 ch0 and ch2 both period=2 loaded same base interval -> tick[0] and tick[2] asserted in same cycle.
REQ-035 rstn low 1 cycle mid-run -> all outputs 0 next cycle, tick_base returns 16 cycles after release; with macro, pause=1 for 20 cycles delays next tick_base by 20 cycles.

Source files
------------

// File: rtl/prescaler_sched.sv
// Prescaled four-channel event scheduler: an N-bit free-running prescaler, four period counters, one-deep config FSM.
// Optional feature: define PRESCALER_SCHED_PAUSE_EN to add a pause input that freezes all timing.
module prescaler_sched #(
  parameter int N = 22,
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         rstn,
`ifdef PRESCALER_SCHED_PAUSE_EN
  input  logic         pause,
`endif
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [1:0]   cfg_ch,
  input  logic [W-1:0] cfg_period,
  input  logic         cfg_mode,
  output logic         tick_base,
  output logic [3:0]   tick,
  output logic [3:0]   busy
);

  // state    | meaning
  // ST_READY | accepting a configuration request (cfg_ready = 1)
  // ST_APPLY | captured request is loaded into its channel at the end of this cycle
  typedef enum logic {ST_READY, ST_APPLY} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic           tick_base_q, tick_base_d;
  logic [3:0]     tick_q, tick_d;
  logic [3:0]     busy_q, busy_d;
  logic [3:0]     mode_q, mode_d;
  logic [W-1:0]   rem_q [4];
  logic [W-1:0]   rem_d [4];
  logic [W-1:0]   per_q [4];
  logic [W-1:0]   per_d [4];
  logic [1:0]     cap_ch_q, cap_ch_d;
  logic [W-1:0]   cap_per_q, cap_per_d;
  logic           cap_mode_q, cap_mode_d;
  logic           run;
  logic           wrap;

`ifdef PRESCALER_SCHED_PAUSE_EN
  assign run = ~pause;
`else
  assign run = 1'b1;
`endif

  assign wrap = run && (cnt_q == {N{1'b1}});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tick_base_d = 1'b0;
    tick_d      = 4'b0000;
    busy_d      = busy_q;
    mode_d      = mode_q;
    rem_d       = rem_q;
    per_d       = per_q;
    cap_ch_d    = cap_ch_q;
    cap_per_d   = cap_per_q;
    cap_mode_d  = cap_mode_q;

    if (run) begin
      cnt_d = cnt_q + N'(1);
    end
    tick_base_d = wrap;

    for (int ch = 0; ch < 4; ch++) begin
      if (wrap && busy_q[ch]) begin
        if (rem_q[ch] > W'(1)) begin
          rem_d[ch] = rem_q[ch] - W'(1);
        end else begin
          tick_d[ch] = 1'b1;
          if (mode_q[ch]) begin
            rem_d[ch] = per_q[ch];
          end else begin
            rem_d[ch]  = '0;
            busy_d[ch] = 1'b0;
          end
        end
      end
    end

    case (state_q)
      ST_READY: begin
        if (cfg_valid) begin
          cap_ch_d   = cfg_ch;
          cap_per_d  = cfg_period;
          cap_mode_d = cfg_mode;
          state_d    = ST_APPLY;
        end
      end
      ST_APPLY: begin
        // The load wins over any expiry or decrement on the same base tick.
        rem_d[cap_ch_q]  = cap_per_q;
        per_d[cap_ch_q]  = cap_per_q;
        mode_d[cap_ch_q] = cap_mode_q;
        busy_d[cap_ch_q] = |cap_per_q;
        tick_d[cap_ch_q] = 1'b0;
        state_d          = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      state_q     <= ST_READY;
      cnt_q       <= '0;
      tick_base_q <= 1'b0;
      tick_q      <= 4'b0000;
      busy_q      <= 4'b0000;
      mode_q      <= 4'b0000;
      cap_ch_q    <= 2'd0;
      cap_per_q   <= '0;
      cap_mode_q  <= 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
        rem_q[ch] <= '0;
        per_q[ch] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tick_base_q <= tick_base_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      cap_ch_q    <= cap_ch_d;
      cap_per_q   <= cap_per_d;
      cap_mode_q  <= cap_mode_d;
      for (int ch = 0; ch < 4; ch++) begin
        rem_q[ch] <= rem_d[ch];
        per_q[ch] <= per_d[ch];
      end
    end
  end

  assign cfg_ready = (state_q == ST_READY);
  assign tick_base = tick_base_q;
  assign tick      = tick_q;
  assign busy      = busy_q;

endmodule
